// File: rtl/direct_mapped_cache_pkg.sv
// Shared definitions for the direct-mapped, write-through cache: FSM encoding,
// default geometry and the saturating counter helper.
package direct_mapped_cache_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_INDEX_W = 2;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2
  } cache_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line storage for the direct-mapped cache: per-line valid bit, tag and one
// data word, with a combinational lookup/tag compare and one write port.
module cache_line_array #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int INDEX_W = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [INDEX_W-1:0]       lookup_index,
  input  logic [DEPTH-INDEX_W-1:0] lookup_tag,
  output logic                     lookup_hit,
  output logic [WIDTH-1:0]         lookup_data,
  input  logic                     wr_en,
  input  logic [INDEX_W-1:0]       wr_index,
  input  logic [DEPTH-INDEX_W-1:0] wr_tag,
  input  logic [WIDTH-1:0]         wr_data
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = DEPTH - INDEX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [WIDTH-1:0] data_mem [LINES];

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag/data storage has no reset; the valid bits alone decide whether
  // a line's contents mean anything, which keeps these arrays plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign lookup_hit  = valid_q[lookup_index] && (tag_mem[lookup_index] == lookup_tag);
  assign lookup_data = data_mem[lookup_index];

endmodule

// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-through, no-write-allocate cache in front of a simple
// RAM. Read hits complete in one cycle; read misses fetch one word from RAM.
module direct_mapped_cache
  import direct_mapped_cache_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [DEPTH-1:0] cpu_adress,
  input  logic [WIDTH-1:0] cpu_data_in,
  output logic             cpu_ready,
  output logic [WIDTH-1:0] cpu_data_out,
  output logic             cpu_valid,
  output logic             cpu_hit,
  output logic [DEPTH-1:0] mem_adress,
  output logic [WIDTH-1:0] mem_data_in,
  output logic             mem_write_enable,
  output logic             mem_read_enable,
  input  logic [WIDTH-1:0] mem_data_out,
  input  logic             mem_valid_out,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
);

  localparam int TAG_W = DEPTH - INDEX_W;

  cache_state_t     state;
  logic [DEPTH-1:0] miss_adress;

  logic             lookup_hit;
  logic [WIDTH-1:0] lookup_data;
  logic             wr_en;
  logic [INDEX_W-1:0] wr_index;
  logic [TAG_W-1:0]   wr_tag;
  logic [WIDTH-1:0]   wr_data;

  cache_line_array #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .INDEX_W (INDEX_W)
  ) u_lines (
    .clk          (clk),
    .reset_n      (reset_n),
    .lookup_index (cpu_adress[INDEX_W-1:0]),
    .lookup_tag   (cpu_adress[DEPTH-1:INDEX_W]),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data),
    .wr_en        (wr_en),
    .wr_index     (wr_index),
    .wr_tag       (wr_tag),
    .wr_data      (wr_data)
  );

  // Single line write port: a miss fill takes priority, otherwise a write hit
  // updates the line in place (write-through keeps RAM coherent).
  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    wr_en    = 1'b0;
    wr_index = cpu_adress[INDEX_W-1:0];
    wr_tag   = cpu_adress[DEPTH-1:INDEX_W];
    wr_data  = cpu_data_in;
    if (state == MISS_WAIT && mem_valid_out) begin
      wr_en    = 1'b1;
      wr_index = miss_adress[INDEX_W-1:0];
      wr_tag   = miss_adress[DEPTH-1:INDEX_W];
      wr_data  = mem_data_out;
    end else if (state == IDLE && cpu_req && cpu_we && lookup_hit) begin
      wr_en = 1'b1;
    end
  end

  assign cpu_ready = (state == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      miss_adress      <= '0;
      cpu_data_out     <= '0;
      cpu_valid        <= 1'b0;
      cpu_hit          <= 1'b0;
      mem_adress       <= '0;
      mem_data_in      <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      hit_count        <= '0;
      miss_count       <= '0;
    end else begin
      cpu_valid        <= 1'b0;
      cpu_hit          <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;

      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (cpu_we) begin
              mem_write_enable <= 1'b1;
              mem_adress       <= cpu_adress;
              mem_data_in      <= cpu_data_in;
              cpu_valid        <= 1'b1;
              cpu_hit          <= lookup_hit;
            end else if (lookup_hit) begin
              cpu_valid    <= 1'b1;
              cpu_hit      <= 1'b1;
              cpu_data_out <= lookup_data;
              hit_count    <= sat_inc(hit_count);
            end else begin
              // The read strobe is raised here so it is high for exactly the
              // one cycle spent in MISS_REQ.
              miss_adress     <= cpu_adress;
              mem_adress      <= cpu_adress;
              mem_read_enable <= 1'b1;
              miss_count      <= sat_inc(miss_count);
              state           <= MISS_REQ;
            end
          end
        end

        MISS_REQ: begin
          state <= MISS_WAIT;
        end

        MISS_WAIT: begin
          if (mem_valid_out) begin
            cpu_valid    <= 1'b1;
            cpu_data_out <= mem_data_out;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/direct_mapped_cache.md
DIRECT_MAPPED_CACHE -- requirements
Module: direct_mapped_cache

Interface
REQ-001 Parameter WIDTH, default 32, data word width.
REQ-002 Parameter DEPTH, default 4, address width in bits, equal to the downstream RAM DEPTH.
REQ-003 Parameter INDEX_W, default 2, line-index width; lines = 2^INDEX_W, TAG_W = DEPTH-INDEX_W.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 cpu_req  input  1  request strobe, sampled only while cpu_ready=1.
REQ-007 cpu_we  input  1  1=write, 0=read.
REQ-008 cpu_adress  input  DEPTH  word address.
REQ-009 cpu_data_in  input  WIDTH  write data.
REQ-010 cpu_ready  output  1  cache can accept a request this cycle.
REQ-011 cpu_data_out  output  WIDTH  read data, meaningful when cpu_valid=1.
REQ-012 cpu_valid  output  1  one-cycle completion pulse (read data or write ack).
REQ-013 cpu_hit  output  1  qualifies cpu_valid: 1=served from cache.
REQ-014 mem_adress, mem_data_in  output  DEPTH, WIDTH  RAM address and write data.
REQ-015 mem_write_enable, mem_read_enable  output  1  one-cycle RAM strobes.
REQ-016 mem_data_out, mem_valid_out  input  WIDTH, 1  RAM read data and its valid pulse.
REQ-017 hit_count, miss_count  output  16  saturating read hit/miss counters.

Function
REQ-018 Index = adress[INDEX_W-1:0]; tag = adress[DEPTH-1:INDEX_W]; each line holds valid bit, tag, one data word.
REQ-019 FSM states: IDLE, MISS_REQ, MISS_WAIT; cpu_ready=1 only in IDLE.
REQ-020 IDLE, read hit: next cycle cpu_valid=1, cpu_hit=1, cpu_data_out=line data; hit_count+1; stay IDLE (latency 1).
REQ-021 IDLE, read miss: latch address, go MISS_REQ; miss_count+1.
REQ-022 MISS_REQ: mem_read_enable=1, mem_adress=latched address for exactly one cycle; go MISS_WAIT.
REQ-023 MISS_WAIT: on mem_valid_out=1, fill line (valid=1, tag, data=mem_data_out); next cycle cpu_valid=1, cpu_hit=0, cpu_data_out=mem_data_out; go IDLE.
REQ-024 IDLE, write: write-through, no-write-allocate; next cycle mem_write_enable=1, mem_adress/mem_data_in=request; cpu_valid=1, cpu_hit=hit; on hit line data updated same edge; stay IDLE; counters unchanged.
REQ-025 Back-to-back requests in IDLE accepted every cycle; write-then-read of same address returns new data.
REQ-026 cpu_req while cpu_ready=0 ignored, not queued.
REQ-027 mem_valid_out outside MISS_WAIT ignored.
REQ-028 Counters saturate at 16'hFFFF, never wrap.
REQ-029 mem strobes and cpu_valid never asserted in the same cycle as reset release.

Reset
REQ-030 reset_n=0 immediately: state IDLE, all valid bits 0, all outputs 0 except cpu_ready=1, counters 0.
REQ-031 Reset during MISS_REQ/MISS_WAIT aborts miss: no fill, no cpu_valid.
REQ-032 Tag/data arrays need no reset; only valid bits do.

Structure
REQ-033 Shared package holds FSM state encodings and default WIDTH/DEPTH/INDEX_W constants.
REQ-034 One natural sub-module: cache_line_array (valid/tag/data storage, tag compare).
REQ-035 RAM instantiated at top level, not inside this block.

Verification
REQ-036 Post-reset read addr 4'h5 -> miss, mem_read_enable pulse, RAM data 0 returned, cpu_hit=0, miss_count=1.
REQ-037 Write 32'hDEADBEEF to 4'h5 then read 4'h5 -> mem_write_enable pulse, read hit returns 32'hDEADBEEF one cycle after request, hit_count=1.
REQ-038 Read 4'h1 then 4'h5 (same index, different tag) then 4'h1 -> three misses, line 1 evicted each time.
REQ-039 Assert reset_n=0 during MISS_WAIT -> no cpu_valid, cpu_ready=1, next read same address misses.
REQ-040 Force miss_count to 16'hFFFF, one more miss -> remains 16'hFFFF.
REQ-041 cpu_req held during miss -> only first request served, no extra RAM strobes.
